pio_key_debounce: RTL and testbench
===================================

# pio_key_debounce

Parametrised Avalon-MM push-button input port for the Qsys system, the next generation of the key PIO. It adds per-channel synchronisation and debounce, runtime-selectable rising/falling edge capture, and write-1-to-clear edge bits. It sits between the board KEY pins and the Nios II data master, and its level interrupt feeds the processor IRQ line.

## Interface
- WIDTH, 4: number of key channels, 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive clk cycles a synchronised input must differ from the debounced value before the debounced value updates; ≥1. The counter width is clog2(DEBOUNCE_CYCLES+1).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; only bits [WIDTH-1:0] are used.
- in_port  in  WIDTH  raw asynchronous key pins.
- readdata  out  32  registered read data; bits above WIDTH are 0.
- irq  out  1  level interrupt, |(edge_capture & irq_mask).

## Operation
- Register map (RO = read-only, RW = read/write, W1C = write 1 to clear):
  - 0: debounced data, RO.
  - 1: synchronised raw input (sync2), RO.
  - 2: irq_mask, RW.
  - 3: edge_capture, W1C per bit.
  - 4: rise_en, RW.
  - 5: fall_en, RW.
  - 6, 7: read 0, writes ignored.
- Writes to RO addresses have no effect.
- A write occurs when chipselect && !write_n.
- Synchroniser, per bit: sync1 <= in_port; sync2 <= sync1.
- Debounce, per channel, with independent counter cnt[i]:
  - If sync2[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync2[i] and cnt[i] <= 0. This is the update event.
  - Else: cnt[i] <= cnt[i]+1.
- A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 never changes stable.
- Edge detection is asserted only on the update event:
  - rise[i] = update event && sync2[i] == 1.
  - fall[i] = update event && sync2[i] == 0.
- Edge capture, per bit:
  - The bit sets when (rise[i] & rise_en[i]) | (fall[i] & fall_en[i]).
  - The bit clears on a write to address 3 with writedata[i] = 1.
  - If set and clear occur in the same cycle, set wins, so no event is lost.
  - A write with writedata[i] = 0 leaves bit i unchanged.
- irq is combinational from edge_capture & irq_mask. Changing irq_mask changes irq the cycle after the write edge.
- Reset values:
  - sync1, sync2, stable, cnt: 0.
  - irq_mask: 0.
  - rise_en: all ones.
  - fall_en: 0.
  - edge_capture: 0.
  - readdata: 0.
  - irq: 0.
- Reset asserted mid-debounce discards the count and returns every register to its reset value immediately. No edge event is generated on reset release, because stable is 0 and matches a released (0) key.

## Timing
- Read latency is 1: readdata is registered every cycle from the current address, regardless of chipselect.
- Writes take effect at the clk edge that samples them.
- Input latency: in_port changes before edge k and stays constant.
  - sync2 shows the new value after edge k+1.
  - stable updates at edge k+1+DEBOUNCE_CYCLES.
  - edge_capture sets at the same edge as stable.
  - irq asserts in the same cycle as edge_capture, if the channel is masked in.
- Debounced data is readable at address 0 one cycle later, through readdata.
- With DEBOUNCE_CYCLES = 1, stable follows sync2 with a 1-cycle lag.
- A bounce (sync2 returning to stable) at any cycle restarts the count from 0.
- The counter never wraps: it holds at most DEBOUNCE_CYCLES-1 before an update or clear.

## Test plan
Bench configuration: WIDTH = 4, DEBOUNCE_CYCLES = 8.
- Reset values: after reset, read addresses 0–5 -> 0, 0, 0, 0, 0xF, 0; irq = 0.
- Debounced rising edge, interrupt and clear:
  - Stimulus: write mask = 0x1; drive in_port[0] high at edge k.
  - Response: edge_capture = 0x1 and irq = 1 at edge k+9; read address 0 -> 0x1.
  - Then write 0x1 to address 3 -> irq drops after that edge.
- Bounce rejection: in_port[1] pulses high for 5 cycles, low for 3, then high steadily -> no capture until 9 edges after the final rise; exactly one capture bit set.
- Falling edge mode:
  - Stimulus: rise_en = 0, fall_en = 0x4; press key 2, then release it.
  - Response: no capture on the press; edge_capture = 0x4 at the release update.
- W1C granularity and the set/clear race:
  - Writing 0x1 with capture = 0x3 leaves 0x2.
  - A clear write landing on the same edge as a new update keeps the bit at 1.
- Reset during a count: assert reset at count 5 with in_port[3] high -> all registers return to reset values. After release, stable[3] = 1 occurs 10 edges later and capture bit 3 sets.

Source files
------------

// File: rtl/pio_key_debounce.sv
// Avalon-MM push-button PIO: per-channel two-flop synchroniser, counter debounce,
// selectable rise/fall edge capture with write-1-to-clear bits, and a level irq.
module pio_key_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] update;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] wdata;
    logic             wr;

    // Bits of writedata above WIDTH carry no meaning for this port.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign wr    = chipselect && !write_n;
    assign wdata = writedata[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // Any cycle where sync2 agrees with stable restarts the count, so only an
    // unbroken run of DEBOUNCE_CYCLES disagreeing samples moves stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        update = '0;
        for (int i = 0; i < WIDTH; i++) begin
            update[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    assign rise     = update & sync2;
    assign fall     = update & ~sync2;
    assign set_bits = (rise & rise_en) | (fall & fall_en);
    assign clr_bits = (wr && address == 3'd3) ? wdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask     <= '0;
            rise_en      <= '1;
            fall_en      <= '0;
            edge_capture <= '0;
        end else begin
            if (wr && address == 3'd2) irq_mask <= wdata;
            if (wr && address == 3'd4) rise_en  <= wdata;
            if (wr && address == 3'd5) fall_en  <= wdata;
            // OR-ing the new events in after the clear means a simultaneous
            // event survives the acknowledge write.
            edge_capture <= (edge_capture & ~clr_bits) | set_bits;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                3'd0:    readdata <= 32'(stable);
                3'd1:    readdata <= 32'(sync2);
                3'd2:    readdata <= 32'(irq_mask);
                3'd3:    readdata <= 32'(edge_capture);
                3'd4:    readdata <= 32'(rise_en);
                3'd5:    readdata <= 32'(fall_en);
                default: readdata <= '0;
            endcase
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_key_debounce.sv
// Bench for pio_key_debounce: window-based reference model checked every cycle,
// plus directed scenarios with hand-computed register and irq expectations.
module tb_pio_key_debounce;

    localparam int W  = 4;
    localparam int DC = 8;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    pio_key_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Reference model: a channel's debounced level flips when the last DC
    // synchronised samples all disagree with it.
    logic [W-1:0] m_sync1, m_sync2, m_stable;
    logic [W-1:0] m_mask, m_rise, m_fall, m_ec;
    logic [W-1:0] hist [DC-1];
    logic [31:0]  m_rd;
    logic         m_irq;

    assign m_irq = |(m_ec & m_mask);

    function automatic logic [W-1:0] flips_now();
        logic [W-1:0] u;
        u = m_sync2 ^ m_stable;
        for (int j = 0; j < DC - 1; j++) u = u & (hist[j] ^ m_stable);
        return u;
    endfunction

    function automatic logic [W-1:0] events_now();
        logic [W-1:0] u;
        u = flips_now();
        return (u & m_sync2 & m_rise) | (u & ~m_sync2 & m_fall);
    endfunction

    function automatic logic [31:0] reg_value(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_stable);
            3'd1:    return 32'(m_sync2);
            3'd2:    return 32'(m_mask);
            3'd3:    return 32'(m_ec);
            3'd4:    return 32'(m_rise);
            3'd5:    return 32'(m_fall);
            default: return 32'd0;
        endcase
    endfunction

    wire m_wr = chipselect && !write_n;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_sync1  <= '0;
            m_sync2  <= '0;
            m_stable <= '0;
            m_mask   <= '0;
            m_rise   <= '1;
            m_fall   <= '0;
            m_ec     <= '0;
            m_rd     <= '0;
            for (int j = 0; j < DC - 1; j++) hist[j] <= '0;
        end else begin
            m_sync1  <= in_port;
            m_sync2  <= m_sync1;
            hist[0]  <= m_sync2;
            for (int j = 1; j < DC - 1; j++) hist[j] <= hist[j-1];
            m_stable <= m_stable ^ flips_now();
            m_rd     <= reg_value(address);
            if (m_wr && address == 3'd2) m_mask <= writedata[W-1:0];
            if (m_wr && address == 3'd4) m_rise <= writedata[W-1:0];
            if (m_wr && address == 3'd5) m_fall <= writedata[W-1:0];
            if (m_wr && address == 3'd3)
                m_ec <= (m_ec & ~writedata[W-1:0]) | events_now();
            else
                m_ec <= m_ec | events_now();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("model_readdata", readdata, m_rd);
            checkOutput("model_irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1;
        write_n    = 0;
        @(negedge clk);
        chipselect = 0;
        write_n    = 1;
    endtask

    task automatic read_check(input logic [2:0] a, input logic [31:0] exp, input string name);
        address = a;
        @(negedge clk);
        checkOutput(name, readdata, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1;
        address    = 0;
        chipselect = 0;
        write_n    = 1;
        writedata  = 0;
        in_port    = '0;
        idle(3);
        reset  = 0;
        chk_en = 1;

        $display("[TB] reset values");
        read_check(3'd0, 32'h0, "rst_data");
        read_check(3'd1, 32'h0, "rst_sync");
        read_check(3'd2, 32'h0, "rst_mask");
        read_check(3'd3, 32'h0, "rst_edge");
        read_check(3'd4, 32'hF, "rst_rise_en");
        read_check(3'd5, 32'h0, "rst_fall_en");
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);

        $display("[TB] debounced rising edge");
        applyStimulus(3'd2, 32'h1);
        in_port[0] = 1'b1;
        idle(9);
        checkOutput("rise_irq_early", {31'd0, irq}, 32'd0);
        idle(1);
        checkOutput("rise_irq_set", {31'd0, irq}, 32'd1);
        read_check(3'd0, 32'h1, "rise_data");
        read_check(3'd3, 32'h1, "rise_edge");
        applyStimulus(3'd3, 32'h1);
        checkOutput("rise_irq_cleared", {31'd0, irq}, 32'd0);

        $display("[TB] bounce rejection");
        applyStimulus(3'd2, 32'h2);
        in_port[1] = 1'b1;
        idle(5);
        in_port[1] = 1'b0;
        idle(3);
        in_port[1] = 1'b1;
        idle(9);
        checkOutput("bounce_irq_early", {31'd0, irq}, 32'd0);
        idle(1);
        checkOutput("bounce_irq_set", {31'd0, irq}, 32'd1);
        read_check(3'd3, 32'h2, "bounce_edge");

        $display("[TB] falling edge mode");
        applyStimulus(3'd4, 32'h0);
        applyStimulus(3'd5, 32'h4);
        in_port[2] = 1'b1;
        idle(12);
        read_check(3'd3, 32'h2, "fall_press_edge");
        in_port[2] = 1'b0;
        idle(12);
        read_check(3'd3, 32'h6, "fall_release_edge");

        $display("[TB] write-1-to-clear");
        applyStimulus(3'd3, 32'h4);
        read_check(3'd3, 32'h2, "w1c_bit2");
        applyStimulus(3'd5, 32'h1);
        in_port[0] = 1'b0;
        idle(12);
        read_check(3'd3, 32'h3, "w1c_pre");
        applyStimulus(3'd3, 32'h1);
        read_check(3'd3, 32'h2, "w1c_bit0");

        $display("[TB] set/clear race");
        applyStimulus(3'd4, 32'hF);
        applyStimulus(3'd5, 32'h0);
        in_port[3] = 1'b1;
        idle(9);
        applyStimulus(3'd3, 32'h8);
        read_check(3'd3, 32'hA, "race_edge");
        read_check(3'd0, 32'hA, "race_data");
        applyStimulus(3'd0, 32'hF);
        read_check(3'd0, 32'hA, "ro_write_ignored");
        applyStimulus(3'd6, 32'hF);
        read_check(3'd6, 32'h0, "addr6_zero");
        read_check(3'd7, 32'h0, "addr7_zero");
        applyStimulus(3'd3, 32'hF);
        read_check(3'd3, 32'h0, "clear_all");
        checkOutput("clear_all_irq", {31'd0, irq}, 32'd0);

        $display("[TB] reset during count");
        in_port = '0;
        idle(12);
        in_port[3] = 1'b1;
        idle(7);
        #2 reset = 1;
        @(negedge clk);
        checkOutput("midrst_readdata", readdata, 32'h0);
        checkOutput("midrst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 0;
        read_check(3'd2, 32'h0, "midrst_mask");
        read_check(3'd4, 32'hF, "midrst_rise_en");
        read_check(3'd5, 32'h0, "midrst_fall_en");
        applyStimulus(3'd2, 32'h8);
        idle(5);
        checkOutput("midrst_irq_early", {31'd0, irq}, 32'd0);
        idle(1);
        checkOutput("midrst_irq_set", {31'd0, irq}, 32'd1);
        read_check(3'd0, 32'h8, "midrst_data");
        read_check(3'd3, 32'h8, "midrst_edge");

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
